// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: counts in-flight writes to each
// architectural register between issue and writeback, and answers busy queries.
module reg_scoreboard #(
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       issue_valid,
    input  logic       issue_writes_rd,
    input  logic [4:0] issue_rd,
    output logic       issue_stall,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic [4:0] query_rs1,
    input  logic [4:0] query_rs2,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       hazard,
    output logic [7:0] inflight_total,
    output logic       underflow_err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Entry 0 is tied to zero so that x0 always reads as idle.
    logic [CNT_W-1:0] cnt_q [0:31];
    logic [CNT_W-1:0] cnt_d [0:31];
    logic [7:0]       total_q;
    logic [7:0]       total_d;
    logic             uerr_q;
    logic             uerr_d;

    logic issue_req_s;
    logic issue_fire_s;
    logic wb_fire_s;
    logic same_rd_s;
    logic wb_counts_s;
    logic wb_under_s;

    // Issue/writeback qualification from registered counters only.
    always_comb begin
        issue_req_s  = issue_valid && issue_writes_rd && (issue_rd != 5'd0);
        issue_stall  = issue_req_s && (cnt_q[issue_rd] == CNT_MAX);
        issue_fire_s = issue_req_s && !issue_stall;
        wb_fire_s    = wb_valid && (wb_rd != 5'd0);
        same_rd_s    = issue_fire_s && (issue_rd == wb_rd);
        wb_counts_s  = wb_fire_s && ((cnt_q[wb_rd] != CNT_ZERO) || same_rd_s);
        wb_under_s   = wb_fire_s && (cnt_q[wb_rd] == CNT_ZERO) && !same_rd_s;
    end

    // Busy queries read the registered counters with no writeback bypass.
    always_comb begin
        rs1_busy = (query_rs1 != 5'd0) && (cnt_q[query_rs1] != CNT_ZERO);
        rs2_busy = (query_rs2 != 5'd0) && (cnt_q[query_rs2] != CNT_ZERO);
        hazard   = rs1_busy || rs2_busy;
    end

    // Next-state counters; a same-register issue and writeback cancel out.
    always_comb begin
        cnt_d[0] = CNT_ZERO;
        for (int r = 1; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue_fire_s && (issue_rd == 5'(r)) && !(wb_fire_s && (wb_rd == 5'(r)))) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (wb_fire_s && (wb_rd == 5'(r)) && !(issue_fire_s && (issue_rd == 5'(r)))
                         && (cnt_q[r] != CNT_ZERO)) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
    end

    // Next-state running total and sticky underflow flag.
    always_comb begin
        total_d = total_q;
        uerr_d  = uerr_q || wb_under_s;
        case ({issue_fire_s, wb_counts_s})
            2'b10:   total_d = total_q + 8'd1;
            2'b01:   total_d = total_q - 8'd1;
            default: total_d = total_q;
        endcase
    end

    // State registers; reset outranks flush, and flush leaves the error flag alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= CNT_ZERO;
            end
            total_q <= 8'd0;
            uerr_q  <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= CNT_ZERO;
            end
            total_q <= 8'd0;
            uerr_q  <= uerr_q;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            total_q <= total_d;
            uerr_q  <= uerr_d;
        end
    end

    assign inflight_total = total_q;
    assign underflow_err  = uerr_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table with hand
// expectations, then random traffic against a counting reference model.
module tb_reg_scoreboard;

    localparam int MAXI = 3;

    logic       clk = 1'b0;
    logic       reset, flush, issue_valid, issue_writes_rd, wb_valid;
    logic [4:0] issue_rd, wb_rd, query_rs1, query_rs2;
    logic       issue_stall, rs1_busy, rs2_busy, hazard, underflow_err;
    logic [7:0] inflight_total;

    int n_cmp = 0;
    int n_bad = 0;

    int mcnt [32];
    int mtot;
    int muerr;

    always #5 clk = ~clk;

    reg_scoreboard #(.MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_writes_rd(issue_writes_rd),
        .issue_rd(issue_rd), .issue_stall(issue_stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .hazard(hazard),
        .inflight_total(inflight_total), .underflow_err(underflow_err)
    );

    typedef struct {
        logic       rst, fl, iv, iw;
        logic [4:0] ird;
        logic       wv;
        logic [4:0] wrd, q1, q2;
        logic       e_st, e_b1, e_b2, e_hz;
        int         e_tot;
        logic       e_ue;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                                input logic iw, input int ird, input logic wv,
                                input int wrd, input int q1, input int q2,
                                input logic st, input logic b1, input logic b2,
                                input int tot, input logic ue);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.iw = iw; v.ird = 5'(ird);
        v.wv = wv; v.wrd = 5'(wrd); v.q1 = 5'(q1); v.q2 = 5'(q2);
        v.e_st = st; v.e_b1 = b1; v.e_b2 = b2; v.e_hz = b1 | b2;
        v.e_tot = tot; v.e_ue = ue;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int mbusy(input logic [4:0] q);
        return (q != 5'd0 && mcnt[q] != 0) ? 1 : 0;
    endfunction

    // Reference model: simple per-register counts; the total is recomputed as their sum.
    task automatic model_step(input logic rst, input logic fl, input logic iv, input logic iw,
                              input logic [4:0] ird, input logic wv, input logic [4:0] wrd);
        int st;
        if (rst) begin
            for (int r = 0; r < 32; r++) mcnt[r] = 0;
            muerr = 0;
        end else if (fl) begin
            for (int r = 0; r < 32; r++) mcnt[r] = 0;
        end else begin
            st = (iv && iw && ird != 5'd0 && mcnt[ird] == MAXI) ? 1 : 0;
            if (iv && iw && ird != 5'd0 && st == 0) mcnt[ird]++;
            if (wv && wrd != 5'd0) begin
                if (mcnt[wrd] > 0) mcnt[wrd]--;
                else muerr = 1;
            end
        end
        mtot = 0;
        for (int r = 1; r < 32; r++) mtot += mcnt[r];
    endtask

    // One clock: drive, check combinational outputs, clock, check registered outputs.
    task automatic step(input vec_t v, input bit hand);
        @(negedge clk);
        reset = v.rst; flush = v.fl; issue_valid = v.iv; issue_writes_rd = v.iw;
        issue_rd = v.ird; wb_valid = v.wv; wb_rd = v.wrd;
        query_rs1 = v.q1; query_rs2 = v.q2;
        #1;
        check("stall_pre", int'(issue_stall),
              (v.iv && v.iw && v.ird != 5'd0 && mcnt[v.ird] == MAXI) ? 1 : 0);
        check("rs1_busy_pre", int'(rs1_busy), mbusy(v.q1));
        check("rs2_busy_pre", int'(rs2_busy), mbusy(v.q2));
        check("hazard_pre", int'(hazard), mbusy(v.q1) | mbusy(v.q2));
        if (hand) check("stall_tbl", int'(issue_stall), int'(v.e_st));
        @(posedge clk);
        model_step(v.rst, v.fl, v.iv, v.iw, v.ird, v.wv, v.wrd);
        #1;
        check("total", int'(inflight_total), mtot);
        check("uerr", int'(underflow_err), muerr);
        check("rs1_busy", int'(rs1_busy), mbusy(v.q1));
        check("rs2_busy", int'(rs2_busy), mbusy(v.q2));
        if (hand) begin
            check("total_tbl", int'(inflight_total), v.e_tot);
            check("uerr_tbl", int'(underflow_err), int'(v.e_ue));
            check("rs1_busy_tbl", int'(rs1_busy), int'(v.e_b1));
            check("rs2_busy_tbl", int'(rs2_busy), int'(v.e_b2));
            check("hazard_tbl", int'(hazard), int'(v.e_hz));
        end
    endtask

    vec_t vt [23];

    initial begin
        vec_t rv;
        reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_writes_rd = 1'b0;
        issue_rd = 5'd0; wb_valid = 1'b0; wb_rd = 5'd0; query_rs1 = 5'd0; query_rs2 = 5'd0;
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        mtot = 0; muerr = 0;

        //          rst  fl   iv   iw   ird wv   wrd q1 q2  st   b1   b2   tot ue
        vt[0]  = mk(1'b1,1'b0,1'b0,1'b0, 0,1'b0, 0,  0, 0, 1'b0,1'b0,1'b0, 0,1'b0);
        vt[1]  = mk(1'b0,1'b0,1'b1,1'b1, 5,1'b0, 0,  5, 0, 1'b0,1'b1,1'b0, 1,1'b0);
        vt[2]  = mk(1'b0,1'b0,1'b0,1'b0, 0,1'b1, 5,  5, 0, 1'b0,1'b0,1'b0, 0,1'b0);
        vt[3]  = mk(1'b0,1'b0,1'b1,1'b1, 0,1'b0, 0,  0, 0, 1'b0,1'b0,1'b0, 0,1'b0);
        vt[4]  = mk(1'b0,1'b0,1'b0,1'b0, 0,1'b1, 0,  0, 0, 1'b0,1'b0,1'b0, 0,1'b0);
        vt[5]  = mk(1'b0,1'b0,1'b1,1'b1, 7,1'b0, 0,  7, 0, 1'b0,1'b1,1'b0, 1,1'b0);
        vt[6]  = mk(1'b0,1'b0,1'b1,1'b1, 7,1'b0, 0,  7, 0, 1'b0,1'b1,1'b0, 2,1'b0);
        vt[7]  = mk(1'b0,1'b0,1'b1,1'b1, 7,1'b0, 0,  7, 0, 1'b0,1'b1,1'b0, 3,1'b0);
        vt[8]  = mk(1'b0,1'b0,1'b1,1'b1, 7,1'b0, 0,  7, 0, 1'b1,1'b1,1'b0, 3,1'b0);
        vt[9]  = mk(1'b0,1'b0,1'b1,1'b1, 7,1'b1, 7,  7, 0, 1'b1,1'b1,1'b0, 2,1'b0);
        vt[10] = mk(1'b0,1'b0,1'b1,1'b1, 7,1'b0, 0,  7, 0, 1'b0,1'b1,1'b0, 3,1'b0);
        vt[11] = mk(1'b0,1'b0,1'b0,1'b0, 0,1'b1, 7,  7, 0, 1'b0,1'b1,1'b0, 2,1'b0);
        vt[12] = mk(1'b0,1'b0,1'b0,1'b0, 0,1'b1, 7,  7, 0, 1'b0,1'b1,1'b0, 1,1'b0);
        vt[13] = mk(1'b0,1'b0,1'b0,1'b0, 0,1'b1, 7,  7, 0, 1'b0,1'b0,1'b0, 0,1'b0);
        vt[14] = mk(1'b0,1'b0,1'b1,1'b1, 9,1'b0, 0,  0, 9, 1'b0,1'b0,1'b1, 1,1'b0);
        vt[15] = mk(1'b0,1'b0,1'b1,1'b1, 9,1'b1, 9,  0, 9, 1'b0,1'b0,1'b1, 1,1'b0);
        vt[16] = mk(1'b0,1'b0,1'b0,1'b0, 0,1'b1,12,  0, 9, 1'b0,1'b0,1'b1, 1,1'b1);
        vt[17] = mk(1'b0,1'b0,1'b1,1'b1, 3,1'b0, 0,  3, 9, 1'b0,1'b1,1'b1, 2,1'b1);
        vt[18] = mk(1'b0,1'b0,1'b1,1'b1, 4,1'b0, 0,  3, 4, 1'b0,1'b1,1'b1, 3,1'b1);
        vt[19] = mk(1'b0,1'b1,1'b1,1'b1, 6,1'b0, 0,  6, 3, 1'b0,1'b0,1'b0, 0,1'b1);
        vt[20] = mk(1'b0,1'b0,1'b0,1'b0, 0,1'b0, 0,  6, 4, 1'b0,1'b0,1'b0, 0,1'b1);
        vt[21] = mk(1'b0,1'b0,1'b1,1'b1, 3,1'b0, 0,  3, 0, 1'b0,1'b1,1'b0, 1,1'b1);
        vt[22] = mk(1'b1,1'b1,1'b1,1'b1, 6,1'b0, 0,  3, 6, 1'b0,1'b0,1'b0, 0,1'b0);

        for (int i = 0; i < 23; i++) step(vt[i], 1'b1);

        // Random traffic on a small register window so saturation and underflow recur.
        for (int n = 0; n < 600; n++) begin
            rv = mk(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
                    int'($urandom_range(0, 7)),
                    ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
                    int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 8)),
                    int'($urandom_range(0, 8)),
                    1'b0, 1'b0, 1'b0, 0, 1'b0);
            step(rv, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
